// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcode and FSM types shared by the accumulator calculator
package calc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_OR     = 4'd2,
        OP_EQ     = 4'd3,
        OP_AND    = 4'd4,
        OP_XOR    = 4'd5,
        OP_SHL    = 4'd6,
        OP_SHR    = 4'd7,
        OP_MUL    = 4'd8,
        OP_STORE  = 4'd9,
        OP_RECALL = 4'd10,
        OP_CLEAR  = 4'd11,
        OP_RSV12  = 4'd12,
        OP_RSV13  = 4'd13,
        OP_RSV14  = 4'd14,
        OP_RSV15  = 4'd15
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Bits needed to express a shift amount (or iteration index) within one word
    function automatic int shamt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// rtl/calc_mul_seq.sv - iterative shift-add multiplier, one multiplier bit per cycle
module calc_mul_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = shamt_width(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] step;

    // product already includes the current bit, so it is final while done is high
    assign step    = mplier[0] ? mcand : '0;
    assign product = partial + step;
    assign done    = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mcand   <= '0;
            partial <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            partial <= '0;
            mplier  <= b;
            cnt     <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            partial <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_accum_unit.sv
// rtl/calc_accum_unit.sv - accumulator calculator with register file and sequential multiply
module calc_accum_unit
    import calc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [WIDTH-1:0]  operand,
    input  logic [REG_AW-1:0] reg_sel,
    output logic [WIDTH-1:0]  acc,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_err,
    output logic              result_valid
);

    localparam int SHW = shamt_width(WIDTH);

    state_e             state;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   regs [NUM_REGS];
    logic               carry_q;
    logic               err_q;
    logic               rv_q;

    op_e                op;
    logic               accept;
    logic               reg_ok;
    logic [WIDTH-1:0]   recall_val;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;

    logic [WIDTH-1:0]   alu_acc;
    logic               alu_carry;
    logic               alu_err;
    logic               alu_store;

    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign op           = op_e'(op_code);
    assign op_ready     = (state == ST_IDLE) && !mul_busy;
    assign accept       = op_valid && op_ready;
    assign mul_start    = accept && (op == OP_MUL);

    assign acc          = acc_q;
    assign flag_zero    = (acc_q == '0);
    assign flag_carry   = carry_q;
    assign flag_err     = err_q;
    assign result_valid = rv_q;

    // Guard keeps a non-power-of-two register count from indexing past the file
    assign reg_ok       = (32'(reg_sel) < NUM_REGS);
    assign recall_val   = reg_ok ? regs[reg_sel] : '0;

    // Extra bit on each side captures carry/borrow and the last bit shifted out
    assign shamt        = operand[SHW-1:0];
    assign add_ext      = {1'b0, acc_q} + {1'b0, operand};
    assign sub_ext      = {1'b0, acc_q} - {1'b0, operand};
    assign shl_ext      = {1'b0, acc_q} << shamt;
    assign shr_ext      = {acc_q, 1'b0} >> shamt;

    always_comb begin
        alu_acc   = acc_q;
        alu_carry = carry_q;
        alu_err   = 1'b0;
        alu_store = 1'b0;
        case (op)
            OP_ADD:    {alu_carry, alu_acc} = add_ext;
            OP_SUB:    {alu_carry, alu_acc} = sub_ext;
            OP_OR:     begin alu_acc = acc_q | operand; alu_carry = 1'b0; end
            OP_EQ:     begin alu_acc = (acc_q == operand) ? WIDTH'(1) : '0; alu_carry = 1'b0; end
            OP_AND:    begin alu_acc = acc_q & operand; alu_carry = 1'b0; end
            OP_XOR:    begin alu_acc = acc_q ^ operand; alu_carry = 1'b0; end
            OP_SHL:    {alu_carry, alu_acc} = shl_ext;
            OP_SHR:    begin alu_acc = shr_ext[WIDTH:1]; alu_carry = shr_ext[0]; end
            OP_MUL:    alu_acc = acc_q;
            OP_STORE:  alu_store = 1'b1;
            OP_RECALL: begin alu_acc = recall_val; alu_carry = 1'b0; end
            OP_CLEAR:  begin alu_acc = '0; alu_carry = 1'b0; end
            default:   alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        err_q <= alu_err;
                        if (op == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            acc_q   <= alu_acc;
                            carry_q <= alu_carry;
                            rv_q    <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        acc_q   <= mul_product[WIDTH-1:0];
                        carry_q <= |mul_product[2*WIDTH-1:WIDTH];
                        rv_q    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (accept && alu_store && reg_ok) begin
            regs[reg_sel] <= acc_q;
        end
    end

    calc_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (acc_q),
        .b       (operand),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: doc/calc_accum_unit.md
Name: calc_accum_unit

Overview:
Parametrised successor of the team's 8-bit accumulator calculator. It holds a WIDTH-bit accumulator plus NUM_REGS memory registers and executes a 4-bit opcode set, including a multi-cycle shift-add multiply. Commands are accepted through a valid/ready handshake, and status flags are exposed. It sits behind the top-level pin wrapper, which maps switches and buttons onto the command port and drives the accumulator onto the outputs.

Parameters:
WIDTH, 8, datapath width in bits; power of 2, minimum 4
NUM_REGS, 4, number of memory registers; minimum 2
REG_AW, $clog2(NUM_REGS), register select width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high
op_valid  input  1  command present
op_ready  output  1  unit can accept a command this cycle
op_code  input  4  operation select
operand  input  WIDTH  operand B
reg_sel  input  REG_AW  memory register index for STORE/RECALL
acc  output  WIDTH  accumulator value
flag_zero  output  1  acc == 0 (combinational from acc)
flag_carry  output  1  carry/borrow/overflow of last arithmetic op
flag_err  output  1  last accepted opcode was reserved
result_valid  output  1  one-cycle pulse when a command has completed

Behaviour:
- Reset (rst_n=1, async): acc=0, all memory regs=0, flag_carry=0, flag_err=0, result_valid=0, FSM=IDLE, op_ready=1. Reset mid-multiply aborts it with no partial result.
- Accept = op_valid && op_ready at a clk edge. Inputs are sampled only at accept.
- FSM states: IDLE, MUL.
- IDLE, single-cycle ops: acc and flags update on the accept edge. result_valid=1 for exactly the next cycle. op_ready stays 1, so back-to-back commands are allowed every cycle.
- Opcodes (acc' = new acc, B = operand):
  - 0 ADD: acc' = acc + B mod 2^WIDTH; carry = carry-out.
  - 1 SUB: acc' = acc - B mod 2^WIDTH; carry = borrow (B > acc unsigned).
  - 2 OR; 4 AND; 5 XOR: bitwise; carry = 0.
  - 3 EQ: acc' = (acc == B) ? 1 : 0; carry = 0.
  - 6 SHL / 7 SHR: logical shift by B[$clog2(WIDTH)-1:0]; carry = last bit shifted out (0 if amount = 0).
  - 8 MUL: start multiply (below).
  - 9 STORE: reg[reg_sel] = acc; acc and flags unchanged.
  - 10 RECALL: acc' = reg[reg_sel]; carry = 0.
  - 11 CLEAR: acc' = 0, carry = 0.
  - 12-15 reserved: acc and carry unchanged; flag_err = 1.
- flag_err is cleared on any accepted non-reserved opcode.
- MUL:
  - On accept, latch multiplicand = acc and multiplier = B, clear the product register, and go to MUL. op_ready = 0 from the next cycle.
  - Iterative shift-add, one multiplier bit per cycle, WIDTH cycles.
  - On the final iteration: acc' = low WIDTH bits of the 2*WIDTH product; carry = (high WIDTH bits != 0); return to IDLE. op_ready = 1 and result_valid = 1 in the following cycle.
  - Total: accept edge to acc update = WIDTH cycles.
- op_valid while op_ready=0 is ignored and not queued. Multiply by 0 still takes the full WIDTH cycles.
- acc is visible continuously; flag_zero tracks it with no latency.

Decomposition:
- Package calc_pkg: opcode enum type op_e (the 16 encodings above), FSM state enum, localparam helper for shift-amount width.
- One sub-module: calc_mul_seq (WIDTH param). Ports: start, a, b, busy, done, product[2*WIDTH-1:0].
- The top module holds the acc, the register file, flags, the handshake, and the single-cycle ALU case.

Test Plan:
- WIDTH=8. Reset, ADD 200 then ADD 100 -> acc=44, flag_carry=1, result_valid pulses once per op, op_ready never drops.
- acc=5, SUB 7 -> acc=254, carry=1. Then EQ 254 -> acc=1, carry=0. Then SUB 1 -> acc=0, flag_zero=1.
- acc=12, MUL 11 -> op_ready low for 8 cycles, op_valid pulses during busy ignored, acc=132, carry=0. Then MUL 2 -> acc=8, carry=1 (264).
- STORE 77 into reg 2, CLEAR, RECALL reg 2 -> acc=77. Opcode 13 -> acc=77 held, flag_err=1. Then OR 0 -> flag_err=0.
- acc=0x81, SHL 1 -> acc=0x02, carry=1. SHR 2 -> acc=0x00, carry=1 (bit 1 was the last bit shifted out).
- Start MUL, assert rst_n mid-operation -> acc=0, op_ready=1 immediately, no result_valid. Re-run MUL 3*3 -> acc=9.
